// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and pointer-width helper for sync_fifo
package fifo_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_DEPTH        = 16;
  localparam int DEF_ALM_FULL_TH  = 2;
  localparam int DEF_ALM_EMPTY_TH = 2;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port storage, synchronous write and read, no reset
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wren,
  input  logic [ADDR_W-1:0] i_wraddr,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  input  logic [ADDR_W-1:0] i_rdaddr,
  output logic [DATA_W-1:0] o_rddata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rddata;

  // Read-before-write: a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (i_wren) r_mem[i_wraddr] <= i_wrdata;
    if (i_rden) r_rddata <= r_mem[i_rdaddr];
  end

  assign o_rddata = r_rddata;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered status flags and error pulses
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int ALM_FULL_TH  = DEF_ALM_FULL_TH,
  parameter int ALM_EMPTY_TH = DEF_ALM_EMPTY_TH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       i_wrdata,
  input  logic                    i_wren,
  input  logic                    i_rden,
  output logic [DATA_W-1:0]       o_rddata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_alm_full,
  output logic                    o_alm_empty,
  output logic [ptr_w(DEPTH):0]   o_count,
  output logic                    o_overflow,
  output logic                    o_underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF    = CNT_W'(DEPTH - ALM_FULL_TH);
  localparam logic [CNT_W-1:0] C_AE    = CNT_W'(ALM_EMPTY_TH);

  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_full, r_empty, r_alm_full, r_alm_empty;
  logic              r_overflow, r_underflow, r_rd_clr;
  logic              w_wr_acc, w_rd_acc;
  logic [DATA_W-1:0] w_mem_rddata;

  // A write into a full FIFO is legal only when a read frees a slot this cycle.
  assign w_wr_acc = !reset && i_wren && (!r_full || i_rden);
  assign w_rd_acc = !reset && i_rden && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_alm_full  <= 1'b0;
      r_alm_empty <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rd_clr    <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_rd_acc) r_rd_clr <= 1'b0;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == C_DEPTH);
      r_empty     <= (w_count_nxt == '0);
      r_alm_full  <= (w_count_nxt >= C_AF);
      r_alm_empty <= (w_count_nxt <= C_AE);
      r_overflow  <= i_wren && r_full && !i_rden;
      r_underflow <= i_rden && r_empty;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk      (clk),
    .i_wren   (w_wr_acc),
    .i_wraddr (r_wr_ptr),
    .i_wrdata (i_wrdata),
    .i_rden   (w_rd_acc),
    .i_rdaddr (r_rd_ptr),
    .o_rddata (w_mem_rddata)
  );

  // Storage has no reset, so read data is masked to zero until the first read after reset.
  assign o_rddata    = r_rd_clr ? '0 : w_mem_rddata;
  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_alm_full  = r_alm_full;
  assign o_alm_empty = r_alm_empty;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] i_wrdata = '0;
  logic       i_wren = 1'b0;
  logic       i_rden = 1'b0;
  logic [7:0] o_rddata;
  logic       o_full, o_empty, o_alm_full, o_alm_empty;
  logic [4:0] o_count;
  logic       o_overflow, o_underflow;

  int n_vec = 0;
  int n_err = 0;

  sync_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .i_wrdata    (i_wrdata),
    .i_wren      (i_wren),
    .i_rden      (i_rden),
    .o_rddata    (o_rddata),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_alm_full  (o_alm_full),
    .o_alm_empty (o_alm_empty),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic we, input logic re, input logic [7:0] d);
    reset    = rst;
    i_wren   = we;
    i_rden   = re;
    i_wrdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with a concurrent write request
    step(1'b1, 1'b1, 1'b0, 8'h77);
    step(1'b1, 1'b1, 1'b1, 8'h77);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_alm_empty", 32'(o_alm_empty), 32'd1);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_alm_full", 32'(o_alm_full), 32'd0);
    chk("rst_rddata", 32'(o_rddata), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_udf", 32'(o_underflow), 32'd0);

    // fill 0x00..0x0F
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'(k - 1));
      chk("fill_count", 32'(o_count), 32'(k));
      if (k == 1)  chk("fill1_empty", 32'(o_empty), 32'd0);
      if (k == 2)  chk("ae_at2", 32'(o_alm_empty), 32'd1);
      if (k == 3)  chk("ae_at3", 32'(o_alm_empty), 32'd0);
      if (k == 13) chk("af_at13", 32'(o_alm_full), 32'd0);
      if (k == 14) chk("af_at14", 32'(o_alm_full), 32'd1);
      if (k == 15) chk("full_at15", 32'(o_full), 32'd0);
      if (k == 16) chk("full_at16", 32'(o_full), 32'd1);
    end

    // rejected 17th write
    step(1'b0, 1'b1, 1'b0, 8'hEE);
    chk("ovf_pulse", 32'(o_overflow), 32'd1);
    chk("ovf_count", 32'(o_count), 32'd16);
    chk("ovf_full", 32'(o_full), 32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_clear", 32'(o_overflow), 32'd0);

    // simultaneous write and read while full
    step(1'b0, 1'b1, 1'b1, 8'h10);
    chk("fullrw_count", 32'(o_count), 32'd16);
    chk("fullrw_full", 32'(o_full), 32'd1);
    chk("fullrw_data", 32'(o_rddata), 32'h00);
    chk("fullrw_ovf", 32'(o_overflow), 32'd0);

    // drain: expect 0x01..0x0F then 0x10
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("drain_data", 32'(o_rddata), (k == 16) ? 32'h10 : 32'(k));
      chk("drain_count", 32'(o_count), 32'(16 - k));
      if (k == 3) chk("af_at13_dn", 32'(o_alm_full), 32'd0);
      if (k == 16) chk("drain_empty", 32'(o_empty), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("hold_data", 32'(o_rddata), 32'h10);

    // read when empty with concurrent write
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    chk("udf_pulse", 32'(o_underflow), 32'd1);
    chk("udf_count", 32'(o_count), 32'd1);
    chk("udf_hold", 32'(o_rddata), 32'h10);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("udf_read", 32'(o_rddata), 32'hA5);
    chk("udf_clear", 32'(o_underflow), 32'd0);
    chk("udf_empty", 32'(o_empty), 32'd1);

    // mid-operation reset at count 9
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0, 8'(8'h30 + k));
    chk("pre_rst_count", 32'(o_count), 32'd9);
    step(1'b1, 1'b1, 1'b0, 8'hFF);
    chk("mid_rst_count", 32'(o_count), 32'd0);
    chk("mid_rst_empty", 32'(o_empty), 32'd1);
    chk("mid_rst_rddata", 32'(o_rddata), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h50);
    step(1'b0, 1'b1, 1'b0, 8'h51);
    chk("post_rst_count", 32'(o_count), 32'd2);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("post_rst_rd0", 32'(o_rddata), 32'h50);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("post_rst_rd1", 32'(o_rddata), 32'h51);
    chk("post_rst_empty", 32'(o_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of entries; it SHALL be a power of 2 and at least 4.
REQ-003 SHALL have parameter ALM_FULL_TH, default 2, meaning the almost-full margin in entries below full.
REQ-004 SHALL have parameter ALM_EMPTY_TH, default 2, meaning the almost-empty level in entries.
REQ-005 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset  input  1  meaning the reset, which is synchronous and active-high.
REQ-007 SHALL have port i_wrdata  input  DATA_W  meaning the write data.
REQ-008 SHALL have port i_wren  input  1  meaning the write request.
REQ-009 SHALL have port i_rden  input  1  meaning the read request.
REQ-010 SHALL have port o_rddata  output  DATA_W  meaning the registered read data.
REQ-011 SHALL have port o_full  output  1  meaning count == DEPTH.
REQ-012 SHALL have port o_empty  output  1  meaning count == 0.
REQ-013 SHALL have port o_alm_full  output  1  meaning count >= DEPTH-ALM_FULL_TH.
REQ-014 SHALL have port o_alm_empty  output  1  meaning count <= ALM_EMPTY_TH.
REQ-015 SHALL have port o_count  output  $clog2(DEPTH)+1  meaning the current occupancy.
REQ-016 SHALL have port o_overflow  output  1  meaning a one-cycle pulse when a write is rejected.
REQ-017 SHALL have port o_underflow  output  1  meaning a one-cycle pulse when a read is rejected.

Function
REQ-018 SHALL accept a write when i_wren=1 and either !o_full, or o_full with i_rden=1 in the same cycle.
REQ-019 SHALL accept a read when i_rden=1 and !o_empty; there is no write-to-read bypass when empty.
REQ-020 SHALL store i_wrdata at wr_ptr and increment wr_ptr modulo DEPTH on each accepted write.
REQ-021 SHALL load mem[rd_ptr] into o_rddata on the clock edge of each accepted read (1-cycle latency) and increment rd_ptr modulo DEPTH.
REQ-022 SHALL hold o_rddata when no read is accepted.
REQ-023 SHALL update o_count as +1 for a write only, -1 for a read only, and unchanged for both or neither.
REQ-024 SHALL drive all status flags as registered outputs derived from the next-state count, so flags are valid in the cycle after the causing edge with no combinational path from inputs.
REQ-025 SHALL pulse o_overflow for one cycle when i_wren=1 and o_full=1 and i_rden=0; FIFO state SHALL be unchanged.
REQ-026 SHALL pulse o_underflow for one cycle when i_rden=1 and o_empty=1; any concurrent write SHALL still be accepted.
REQ-027 SHALL wrap pointers with no data corruption across the DEPTH boundary.

Reset
REQ-028 SHALL, when reset=1 at a clock edge, set the following and take priority over any same-cycle i_wren/i_rden: wr_ptr=0, rd_ptr=0, o_count=0, o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0, o_overflow=0, o_underflow=0.
REQ-029 SHALL leave memory contents unreset; a mid-operation reset SHALL discard all stored entries.

Structure
REQ-030 SHALL place default DATA_W, DEPTH and threshold constants, plus the pointer-width localparam function, in shared package fifo_pkg.
REQ-031 SHALL implement storage in one sub-module fifo_mem (simple dual-port, synchronous write, synchronous read, no reset); flag and pointer control SHALL stay in sync_fifo.

Verification (DEPTH=16, thresholds 2)
REQ-032 SHALL verify: 16 writes of 0x00..0x0F then 16 reads -> data read back in order one cycle after each i_rden; o_full=1 after write 16; o_empty=1 after read 16.
REQ-033 SHALL verify: 17th write when full with i_rden=0 -> o_overflow pulses 1 cycle, o_count stays 16, data unchanged.
REQ-034 SHALL verify: i_rden when empty together with i_wren of 0xA5 -> o_underflow pulses, o_count=1, next read returns 0xA5.
REQ-035 SHALL verify: with the FIFO full, simultaneous write and read -> o_count stays 16, o_full stays 1, oldest word returned.
REQ-036 SHALL verify: flag thresholds -> o_alm_empty=1 at count 2 and 0 at count 3; o_alm_full=1 at count 14 and 0 at count 13.
REQ-037 SHALL verify: reset asserted at count 9 with concurrent i_wren -> next cycle o_count=0, o_empty=1, o_rddata=0; following writes and reads start at entry 0.
